// File: rtl/multi_channel_delay_generator.sv
// NUM_CH independent programmable cycle-delay timers with one-shot/periodic modes,
// abort, global pause and optional auto-start straight out of reset.
module multi_channel_delay_generator #(
  parameter int unsigned          NUM_CH     = 4,
  parameter int unsigned          BW_DELAY   = 32,
  parameter logic [NUM_CH-1:0]    AUTO_START = '0,
  parameter int unsigned          INIT_DELAY = 100
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       pause,
  input  logic [NUM_CH-1:0]          start,
  input  logic [NUM_CH-1:0]          stop,
  input  logic [NUM_CH-1:0]          periodic,
  input  logic [NUM_CH*BW_DELAY-1:0] delay_value,
  output logic [NUM_CH-1:0]          busy,
  output logic [NUM_CH-1:0]          expired_pulse,
  output logic [NUM_CH-1:0]          delay_is_over
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [BW_DELAY-1:0] ONE       = BW_DELAY'(1);
  localparam logic [BW_DELAY-1:0] INIT_LOAD = (INIT_DELAY == 0) ? ONE : BW_DELAY'(INIT_DELAY);

  // High only across the first edge after reset is released, so auto-start loads once.
  logic auto_pend;

  always_ff @(posedge clk) begin
    if (rst) auto_pend <= 1'b1;
    else     auto_pend <= 1'b0;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    state_t              state;
    logic [BW_DELAY-1:0] cnt;
    logic [BW_DELAY-1:0] reload;
    logic                mode;
    logic                pulse_q;
    logic                over_q;
    logic [BW_DELAY-1:0] din;

    // A zero delay is treated as one so the counter never has to wrap.
    assign din = (delay_value[i*BW_DELAY +: BW_DELAY] == '0) ? ONE
               : delay_value[i*BW_DELAY +: BW_DELAY];

    // Priority: reset, stop, start, auto-start, then counting (unless paused).
    always_ff @(posedge clk) begin
      if (rst) begin
        state   <= IDLE;
        cnt     <= '0;
        reload  <= '0;
        mode    <= 1'b0;
        pulse_q <= 1'b0;
        over_q  <= 1'b0;
      end else begin
        pulse_q <= 1'b0;
        if (stop[i]) begin
          state  <= IDLE;
          cnt    <= '0;
          over_q <= 1'b0;
        end else if (start[i]) begin
          state  <= RUN;
          cnt    <= din;
          reload <= din;
          mode   <= periodic[i];
          over_q <= 1'b0;
        end else if (auto_pend && AUTO_START[i]) begin
          state  <= RUN;
          cnt    <= INIT_LOAD;
          reload <= INIT_LOAD;
          mode   <= 1'b0;
        end else if (state == RUN && !pause) begin
          if (cnt == ONE) begin
            pulse_q <= 1'b1;
            over_q  <= 1'b1;
            if (mode) begin
              cnt <= reload;
            end else begin
              state <= IDLE;
              cnt   <= '0;
            end
          end else begin
            cnt <= cnt - ONE;
          end
        end
      end
    end

    assign busy[i]          = (state == RUN);
    assign expired_pulse[i] = pulse_q;
    assign delay_is_over[i] = over_q;
  end

endmodule
